// File: rtl/cpu_evolution_mem_loader_if.sv
// Byte-stream input and single-port RAM bus of the program-image loader.
// The master modport is the loader's side. The slave modport is the stream source and RAM side.
interface cpu_evolution_mem_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        st_data;
    logic              st_valid;
    logic              st_last;
    logic              st_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic              mem_clken;
    logic [31:0]       mem_readdata;

    modport master (
        input  st_data, st_valid, st_last, mem_readdata,
        output st_ready, mem_address, mem_byteenable, mem_chipselect,
               mem_write, mem_writedata, mem_clken
    );

    modport slave (
        output st_data, st_valid, st_last, mem_readdata,
        input  st_ready, mem_address, mem_byteenable, mem_chipselect,
               mem_write, mem_writedata, mem_clken
    );
endinterface

// File: rtl/cpu_evolution_mem_loader.sv
// Packs a little-endian byte stream into 32-bit RAM words, then reads the image back.
// The CPU is released only when the sum of the read-back words matches the sum of the written words.
module cpu_evolution_mem_loader #(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    cpu_evolution_mem_loader_if.master   bus,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic                         verify_ok,
    output logic [ADDR_W:0]              word_count,
    output logic [31:0]                  checksum
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_VERIFY,
        S_DONE
    } state_e;

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        idx_q, idx_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       word_q, word_d;
    logic              last_q, last_d;
    logic              error_q, error_d;
    logic              vok_q, vok_d;
    logic [ADDR_W:0]   wc_q, wc_d;
    logic [31:0]       sum_q, sum_d;
    logic [31:0]       rsum_q, rsum_d;
    logic [ADDR_W:0]   vcnt_q, vcnt_d;

    logic              reading;
    logic [31:0]       read_mask;
    logic [31:0]       rd_word;

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            idx_q   <= '0;
            be_q    <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            error_q <= 1'b0;
            vok_q   <= 1'b0;
            wc_q    <= '0;
            sum_q   <= '0;
            rsum_q  <= '0;
            vcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            word_q  <= word_d;
            last_q  <= last_d;
            error_q <= error_d;
            vok_q   <= vok_d;
            wc_q    <= wc_d;
            sum_q   <= sum_d;
            rsum_q  <= rsum_d;
            vcnt_q  <= vcnt_d;
        end
    end

    // be_q still holds the final write's lanes during VERIFY; the unwritten lanes of the last word hold stale RAM data.
    assign read_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
    assign rd_word   = (vcnt_q == wc_q) ? (bus.mem_readdata & read_mask) : bus.mem_readdata;

    // NOTE: every _d gets its hold value first, so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        be_d    = be_q;
        word_d  = word_q;
        last_d  = last_q;
        error_d = error_q;
        vok_d   = vok_q;
        wc_d    = wc_q;
        sum_d   = sum_q;
        rsum_d  = rsum_q;
        vcnt_d  = vcnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    vok_d   = 1'b0;
                    wc_d    = '0;
                    sum_d   = '0;
                    rsum_d  = '0;
                    idx_d   = '0;
                    be_d    = '0;
                    word_d  = '0;
                    last_d  = 1'b0;
                    addr_d  = BASE;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.st_valid) begin
                    word_d[{idx_q[1:0], 3'b000} +: 8] = bus.st_data;
                    be_d[idx_q[1:0]] = 1'b1;
                    idx_d = idx_q + 3'd1;
                    if (bus.st_last) begin
                        last_d = 1'b1;
                    end
                    if (idx_q == 3'd3 || bus.st_last) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                sum_d = sum_q + word_q;
                wc_d  = wc_q + (ADDR_W + 1)'(1);
                if (last_q) begin
                    vcnt_d  = '0;
                    rsum_d  = '0;
                    state_d = S_VERIFY;
                end else if (addr_q == LAST_ADDR) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    idx_d   = '0;
                    be_d    = '0;
                    word_d  = '0;
                    state_d = S_LOAD;
                end
            end
            S_VERIFY: begin
                // Cycle k issues read k; the data of read k-1 is captured in the same cycle.
                vcnt_d = vcnt_q + (ADDR_W + 1)'(1);
                if (vcnt_q != '0) begin
                    rsum_d = rsum_q + rd_word;
                end
                if (vcnt_q == wc_q) begin
                    vok_d   = (rsum_d == sum_q) && !error_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus strobes decode from the asynchronously reset state, so reset drops them without waiting for a clock edge.
    always_comb begin
        busy    = (state_q == S_LOAD) || (state_q == S_WRITE) || (state_q == S_VERIFY);
        done    = (state_q == S_DONE);
        reading = (state_q == S_VERIFY) && (vcnt_q < wc_q);

        bus.st_ready       = (state_q == S_LOAD);
        bus.mem_clken      = busy;
        bus.mem_chipselect = (state_q == S_WRITE) || reading;
        bus.mem_write      = (state_q == S_WRITE);
        bus.mem_address    = '0;
        bus.mem_byteenable = 4'h0;
        bus.mem_writedata  = '0;
        if (state_q == S_WRITE) begin
            bus.mem_address    = addr_q;
            bus.mem_byteenable = be_q;
            bus.mem_writedata  = word_q;
        end else if (reading) begin
            bus.mem_address    = BASE + vcnt_q[ADDR_W-1:0];
            bus.mem_byteenable = 4'hF;
        end
    end

    assign error      = error_q;
    assign verify_ok  = vok_q;
    assign word_count = wc_q;
    assign checksum   = sum_q;
endmodule
